// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int DATA_W           = 8;
    localparam int BAUD_CNT_DEFAULT = 10417;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;
`endif

endpackage

// File: rtl/tx_fifo.sv
// Synchronous byte FIFO with combinational head read; DEPTH must be a power of two.
// Push while full and pop while empty are ignored.
module tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + AW'(1);
            if (w_doPop)  r_rdPtr <= r_rdPtr + AW'(1);
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_doPush) r_mem[r_wrPtr] <= i_data;
    end

    assign o_head  = r_mem[r_rdPtr];
    assign o_count = r_count;
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/uart_buf_tx.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 serial framer.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frame).
module uart_buf_tx
    import uart_pkg::*;
#(
    parameter int BAUD_CNT   = BAUD_CNT_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    output logic              ready,
    output logic              dout,
    output logic              busy
);

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_CNT - 1);

    tx_state_t                   r_state;
    logic [15:0]                 r_baud;
    logic [2:0]                  r_bitIdx;
    logic [DATA_W-1:0]           r_shift;
    logic                        r_dout;
`ifdef UART_TX_PARITY_EN
    logic                        r_parity;
`endif

    logic                        w_push;
    logic                        w_pop;
    logic                        w_full;
    logic                        w_empty;
    logic [DATA_W-1:0]           w_head;
    logic [$clog2(FIFO_DEPTH):0] w_count;
    logic                        w_baudDone;

    assign w_push     = valid && ready;
    assign w_baudDone = (r_baud == BAUD_LAST);
    assign w_pop      = !w_empty && ((r_state == ST_IDLE) ||
                                     ((r_state == ST_STOP) && w_baudDone));

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_baud   <= '0;
            r_bitIdx <= '0;
            r_shift  <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_baud <= '0;
                    if (w_pop) begin
                        r_shift <= w_head;
`ifdef UART_TX_PARITY_EN
                        r_parity <= ^w_head;
`endif
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_baudDone) begin
                        r_baud  <= '0;
                        r_state <= ST_DATA;
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (w_baudDone) begin
                        r_baud   <= '0;
                        r_shift  <= r_shift >> 1;
                        r_bitIdx <= r_bitIdx + 3'd1;
                        if (r_bitIdx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_baudDone) begin
                        r_baud  <= '0;
                        r_state <= ST_STOP;
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_baudDone) begin
                        r_baud <= '0;
                        // Back-to-back frames: reload straight into START.
                        if (w_pop) begin
                            r_shift <= w_head;
`ifdef UART_TX_PARITY_EN
                            r_parity <= ^w_head;
`endif
                            r_state <= ST_START;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Line level is registered from the state, so it trails the FSM by one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= 1'b1;
        end else begin
            case (r_state)
                ST_START:  r_dout <= 1'b0;
                ST_DATA:   r_dout <= r_shift[0];
`ifdef UART_TX_PARITY_EN
                ST_PARITY: r_dout <= r_parity;
`endif
                default:   r_dout <= 1'b1;
            endcase
        end
    end

    assign dout  = r_dout;
    assign ready = !w_full;
    assign busy  = (r_state != ST_IDLE) || (w_count != '0);

endmodule

// File: tb/tb_uart_buf_tx.sv
// Directed self-checking bench for uart_buf_tx with BAUD_CNT = 4, FIFO_DEPTH = 4.
// Build with UART_TX_PARITY_EN defined to exercise the 11-bit frame.
module tb_uart_buf_tx;

    localparam int BAUD  = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CLKS = FRAME_BITS * BAUD;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic       ready;
    logic       dout;
    logic       busy;

    int         passCount = 0;
    int         failCount = 0;
    int         checkCount = 0;
    logic       doutLog [$];
    logic [7:0] expBytes [$];

    uart_buf_tx #(
        .BAUD_CNT   (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .valid (valid),
        .data  (data),
        .ready (ready),
        .dout  (dout),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Frame bit i (0 = start bit) as it should appear on the line.
    function automatic logic [10:0] frameOf(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b0, 1'b1, b, 1'b0};
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        doutLog.push_back(dout);
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d);
        valid = v;
        data  = d;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) begin
            passCount++;
        end else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Walks the logged line from startIdx expecting expBytes as contiguous frames.
    task automatic checkStream(input string tag, input int startIdx);
        int          pos;
        int          bad;
        logic [10:0] fr;
        pos = startIdx;
        foreach (expBytes[j]) begin
            fr  = frameOf(expBytes[j]);
            bad = 0;
            for (int i = 0; i < FRAME_BITS; i++) begin
                for (int c = 0; c < BAUD; c++) begin
                    if (pos >= doutLog.size() || doutLog[pos] !== fr[i]) bad++;
                    pos++;
                end
            end
            checkOutput($sformatf("%s_frame%0d", tag, j), bad, 0);
        end
        checkOutput({tag, "_idleAfter"}, (pos < doutLog.size()) ? doutLog[pos] : 1'bx, 1'b1);
    endtask

    task automatic runSingle(input string tag, input logic [7:0] b);
        int n;
        n = 0;
        doutLog.delete();
        applyStimulus(1'b1, b);
        tick();
        applyStimulus(1'b0, 8'h00);
        checkOutput({tag, "_busyOnAccept"}, busy, 1);
        tick();
        tick();
        checkOutput({tag, "_doutK1"}, doutLog[1], 1);
        checkOutput({tag, "_doutK2"}, doutLog[2], 0);
        while (busy && n < 200) begin
            tick();
            n++;
        end
        checkOutput({tag, "_busyDropEdge"}, doutLog.size() - 1, FRAME_CLKS + 1);
        tick();
        tick();
        expBytes.delete();
        expBytes.push_back(b);
        checkStream(tag, 2);
        checkOutput({tag, "_busyIdle"}, busy, 0);
    endtask

    initial begin
        int idx;
        int n;
        int firstDrop;
        int firstIdx;
        int sixthIdx;
        int lows;
        logic acc;

        rst = 1'b1;
        applyStimulus(1'b0, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_dout", dout, 1);
        checkOutput("reset_ready", ready, 1);
        checkOutput("reset_busy", busy, 0);

        runSingle("single55", 8'h55);
        runSingle("single07", 8'h07);

        // Hold valid with 0x41..0x46, advancing the byte only when it is taken.
        doutLog.delete();
        idx = 0; n = 0; firstDrop = -1; firstIdx = -1; sixthIdx = -1;
        while ((idx < 6 || busy) && n < 600) begin
            if (idx < 6) applyStimulus(1'b1, 8'h41 + idx[7:0]);
            else         applyStimulus(1'b0, 8'h00);
            acc = (idx < 6) && ready;
            if (idx > 0 && idx < 6 && !ready && firstDrop < 0) firstDrop = idx;
            tick();
            n++;
            if (acc) begin
                if (idx == 0) firstIdx = doutLog.size() - 1;
                if (idx == 5) sixthIdx = doutLog.size() - 1;
                idx++;
            end
        end
        applyStimulus(1'b0, 8'h00);
        checkOutput("burst_acceptedBeforeFull", firstDrop, 5);
        checkOutput("burst_allAccepted", idx, 6);
        checkOutput("burst_sixthAcceptEdge", sixthIdx - firstIdx, FRAME_CLKS + 2);
        checkOutput("burst_busyDropEdge", doutLog.size() - 1, firstIdx + 1 + 6 * FRAME_CLKS);
        tick();
        tick();
        expBytes.delete();
        for (int i = 0; i < 6; i++) expBytes.push_back(8'h41 + 8'(i));
        checkStream("burst", firstIdx + 2);

        // 0x12 sends while 0x34 waits; 0xFF lands on the edge 0x34 is popped.
        doutLog.delete();
        n = 0;
        while ((n < FRAME_CLKS + 2 || busy) && n < 400) begin
            if (n == 0)                   applyStimulus(1'b1, 8'h12);
            else if (n == 1)              applyStimulus(1'b1, 8'h34);
            else if (n == FRAME_CLKS + 1) applyStimulus(1'b1, 8'hFF);
            else                          applyStimulus(1'b0, 8'h00);
            if (n == FRAME_CLKS + 1) checkOutput("pushPop_readyBefore", ready, 1);
            tick();
            if (n == FRAME_CLKS)     checkOutput("pushPop_countBefore", dut.w_count, 1);
            if (n == FRAME_CLKS + 1) checkOutput("pushPop_countAfter", dut.w_count, 1);
            n++;
        end
        applyStimulus(1'b0, 8'h00);
        checkOutput("pushPop_busyDropEdge", doutLog.size() - 1, 1 + 3 * FRAME_CLKS);
        tick();
        tick();
        expBytes.delete();
        expBytes.push_back(8'h12);
        expBytes.push_back(8'h34);
        expBytes.push_back(8'hFF);
        checkStream("pushPop", 2);

        // Reset during DATA bit 3 of 0xA3 with two bytes still queued.
        doutLog.delete();
        for (int c = 0; c < 18; c++) begin
            if (c == 0)      applyStimulus(1'b1, 8'hA3);
            else if (c == 1) applyStimulus(1'b1, 8'h11);
            else if (c == 2) applyStimulus(1'b1, 8'h22);
            else             applyStimulus(1'b0, 8'h00);
            tick();
        end
        applyStimulus(1'b0, 8'h00);
        checkOutput("midRst_busyBefore", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midRst_dout", dout, 1);
        checkOutput("midRst_ready", ready, 1);
        checkOutput("midRst_busy", busy, 0);
        doutLog.delete();
        repeat (3 * FRAME_CLKS) tick();
        lows = 0;
        foreach (doutLog[i]) if (doutLog[i] !== 1'b1) lows++;
        checkOutput("midRst_noStartBit", lows, 0);
        checkOutput("midRst_stillIdle", busy, 0);

        runSingle("postRstC3", 8'hC3);

        if (failCount != 0) $display("[TB] %0d comparisons did not match", failCount);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
